// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM command port between two write and two read burst ports.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (WR0 > WR1 > RD0 > RD1).
module sdram_port_arbiter #(
    parameter int unsigned ASIZE      = 23,
    parameter int unsigned USEW       = 9,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned BURST      = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               INIT_DONE,
    input  logic               LOAD,
    input  logic [4*ASIZE-1:0] BASE_ADDR,
    input  logic [4*ASIZE-1:0] END_ADDR,
    input  logic [2*USEW-1:0]  WR_USE,
    input  logic [2*USEW-1:0]  RD_USE,
    input  logic [1:0]         RD_ACTIVE,
    input  logic               CMD_ACK,
    output logic [2:0]         CMD,
    output logic [ASIZE-1:0]   ADDR,
    output logic [1:0]         WR_STB,
    output logic [1:0]         RD_STB,
    output logic [1:0]         GRANT,
    output logic               BUSY
);

    localparam int unsigned CW = $clog2(BURST + 1);
    localparam logic [2:0] CmdNop   = 3'b000;
    localparam logic [2:0] CmdRead  = 3'b001;
    localparam logic [2:0] CmdWrite = 3'b010;

    typedef logic [ASIZE:0] ext_t;
    localparam logic [CW-1:0]   CntLast  = CW'(BURST - 1);
    localparam logic [USEW-1:0] WrThresh = USEW'(BURST);
    localparam logic [USEW-1:0] RdThresh = USEW'(FIFO_DEPTH - BURST);
    localparam ext_t            BurstA   = ext_t'(BURST);

    typedef enum logic [1:0] {StIdle, StIssue, StData, StAdv} state_e;

    state_e           state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [1:0]       wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, grant_q, grant_d;
    logic             busy_q, busy_d, load_pend_q, load_pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ASIZE-1:0] ptr_q [4];
    logic [ASIZE-1:0] ptr_d [4];
    logic [ASIZE-1:0] base [4];
    logic [ASIZE-1:0] end_a [4];
    logic [3:0]       req;
    logic [1:0]       win;
    ext_t             nxt;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            base[i]  = BASE_ADDR[i*ASIZE +: ASIZE];
            end_a[i] = END_ADDR[i*ASIZE +: ASIZE];
        end
        for (int j = 0; j < 2; j++) begin
            req[j]   = WR_USE[j*USEW +: USEW] >= WrThresh;
            req[j+2] = RD_ACTIVE[j] && (RD_USE[j*USEW +: USEW] <= RdThresh);
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) win = 2'(k);
        end
    end
`else
    logic [1:0] last_q, last_d;
    logic [1:0] idx;
    logic       found;

    // Search starts one past the last grant, wrapping back to it last.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wr_stb_d    = wr_stb_q;
        rd_stb_d    = rd_stb_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        load_pend_d = load_pend_q;
        ptr_d       = ptr_q;
        nxt         = ext_t'(ptr_q[grant_q]) + BurstA;
`ifndef ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (LOAD) begin
                    ptr_d       = base;
                    load_pend_d = 1'b0;
                end
                if (INIT_DONE && (|req)) begin
                    state_d = StIssue;
                    grant_d = win;
                    busy_d  = 1'b1;
                    cmd_d   = win[1] ? CmdRead : CmdWrite;
                    addr_d  = LOAD ? base[win] : ptr_q[win];
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            StIssue: begin
                if (LOAD) load_pend_d = 1'b1;
                if (CMD_ACK) begin
                    state_d = StData;
                    cmd_d   = CmdNop;
                    addr_d  = '0;
                    cnt_d   = '0;
                    if (grant_q[1]) rd_stb_d[grant_q[0]] = 1'b1;
                    else            wr_stb_d[grant_q[0]] = 1'b1;
                end
            end
            StData: begin
                if (LOAD) load_pend_d = 1'b1;
                if (cnt_q == CntLast) begin
                    state_d  = StAdv;
                    wr_stb_d = 2'b00;
                    rd_stb_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAdv: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                // A pending or coincident reload takes precedence over the advance.
                if (LOAD || load_pend_q) begin
                    ptr_d       = base;
                    load_pend_d = 1'b0;
                end else if (nxt > ext_t'(end_a[grant_q])) begin
                    ptr_d[grant_q] = base[grant_q];
                end else begin
                    ptr_d[grant_q] = nxt[ASIZE-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            cmd_q       <= CmdNop;
            addr_q      <= '0;
            wr_stb_q    <= 2'b00;
            rd_stb_q    <= 2'b00;
            grant_q     <= 2'd0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            load_pend_q <= 1'b0;
            for (int i = 0; i < 4; i++) ptr_q[i] <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_q      <= 2'd3;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            load_pend_q <= load_pend_d;
            ptr_q       <= ptr_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign CMD    = cmd_q;
    assign ADDR   = addr_q;
    assign WR_STB = wr_stb_q;
    assign RD_STB = rd_stb_q;
    assign GRANT  = grant_q;
    assign BUSY   = busy_q;

endmodule
